sdram_arbit: RTL and testbench

- Central SDRAM command arbiter. Shares one SDRAM command/address/data bus among four requesters: the init sequencer, the periodic refresh engine, the write burst engine and the read burst engine.
- Holds the bus for the init sequencer until init completes.
- After that, grants refresh, write and read one at a time. Refresh has fixed highest priority; write and read alternate round-robin.
- Drives the selected requester's cmd/ba/addr/dq onto the SDRAM pins.

---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_arbit.sv | 116 +++++++++++
 tb/tb_sdram_arbit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: bus widths, command encodings {cs_n,ras_n,cas_n,we_n}
// and the arbiter state type.
package sdram_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned BA_W   = 2;
  localparam int unsigned DQ_W   = 16;

  localparam logic [3:0] CMD_MRS       = 4'b0000;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_BSTOP     = 4'b0110;
  localparam logic [3:0] CMD_NOP       = 4'b0111;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_REFRESH = 3'd2,
    ST_WRITE   = 3'd3,
    ST_READ    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command bus arbiter: init owns the bus until done, then refresh (fixed
// priority) and write/read (round-robin) are granted one at a time.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = sdram_pkg::ADDR_W,
  parameter int unsigned BA_W   = sdram_pkg::BA_W,
  parameter int unsigned DQ_W   = sdram_pkg::DQ_W
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              refresh_req,
  output logic              refresh_ack,
  input  logic              refresh_end,
  input  logic [3:0]        refresh_cmd,
  input  logic              write_req,
  output logic              write_ack,
  input  logic              write_end,
  input  logic [3:0]        write_cmd,
  input  logic [BA_W-1:0]   write_ba,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DQ_W-1:0]   write_dq,
  input  logic              write_dq_oe,
  input  logic              read_req,
  output logic              read_ack,
  input  logic              read_end,
  input  logic [3:0]        read_cmd,
  input  logic [BA_W-1:0]   read_ba,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [3:0]        sdram_cmd,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_wr;
  logic       r_refresh_ack;
  logic       r_write_ack;
  logic       r_read_ack;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_INIT:    if (init_end) w_next_state = ST_IDLE;
      ST_IDLE: begin
        if (refresh_req)              w_next_state = ST_REFRESH;
        else if (write_req && read_req) w_next_state = r_last_wr ? ST_READ : ST_WRITE;
        else if (write_req)           w_next_state = ST_WRITE;
        else if (read_req)            w_next_state = ST_READ;
      end
      ST_REFRESH: if (refresh_end) w_next_state = ST_IDLE;
      ST_WRITE:   if (write_end)   w_next_state = ST_IDLE;
      ST_READ:    if (read_end)    w_next_state = ST_IDLE;
      default:    w_next_state = ST_INIT;
    endcase
  end

  // Acks are registered on the grant edge so they mark the first cycle of the grant.
  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_last_wr     <= 1'b0;
      r_refresh_ack <= 1'b0;
      r_write_ack   <= 1'b0;
      r_read_ack    <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_refresh_ack <= (r_state == ST_IDLE) && (w_next_state == ST_REFRESH);
      r_write_ack   <= (r_state == ST_IDLE) && (w_next_state == ST_WRITE);
      r_read_ack    <= (r_state == ST_IDLE) && (w_next_state == ST_READ);
      if (r_state == ST_WRITE && write_end)    r_last_wr <= 1'b1;
      else if (r_state == ST_READ && read_end) r_last_wr <= 1'b0;
    end
  end

  assign refresh_ack = r_refresh_ack;
  assign write_ack   = r_write_ack;
  assign read_ack    = r_read_ack;

  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_ba     = '0;
    sdram_addr   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      ST_REFRESH: sdram_cmd = refresh_cmd;
      ST_WRITE: begin
        sdram_cmd    = write_cmd;
        sdram_ba     = write_ba;
        sdram_addr   = write_addr;
        sdram_dq_out = write_dq;
        sdram_dq_oe  = write_dq_oe;
      end
      ST_READ: begin
        sdram_cmd  = read_cmd;
        sdram_ba   = read_ba;
        sdram_addr = read_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized bench for sdram_arbit: behavioural requesters plus a bus-ownership
// reference model checked every cycle.
module tb_sdram_arbit;

  localparam int AW = 13;
  localparam int BW = 2;
  localparam int DW = 16;

  // bench-side bus owner codes
  localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

  logic          sysclk_100M = 1'b0;
  logic          rst_n;
  logic          init_end;
  logic [3:0]    init_cmd;
  logic [BW-1:0] init_ba;
  logic [AW-1:0] init_addr;
  logic          refresh_req, refresh_ack, refresh_end;
  logic [3:0]    refresh_cmd;
  logic          write_req, write_ack, write_end;
  logic [3:0]    write_cmd;
  logic [BW-1:0] write_ba;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_dq;
  logic          write_dq_oe;
  logic          read_req, read_ack, read_end;
  logic [3:0]    read_cmd;
  logic [BW-1:0] read_ba;
  logic [AW-1:0] read_addr;
  logic [3:0]    sdram_cmd;
  logic [BW-1:0] sdram_ba;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_dq_out;
  logic          sdram_dq_oe;

  sdram_arbit #(.ADDR_W(AW), .BA_W(BW), .DQ_W(DW)) u_dut (
    .sysclk_100M(sysclk_100M), .rst_n(rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .refresh_req(refresh_req), .refresh_ack(refresh_ack), .refresh_end(refresh_end),
    .refresh_cmd(refresh_cmd),
    .write_req(write_req), .write_ack(write_ack), .write_end(write_end),
    .write_cmd(write_cmd), .write_ba(write_ba), .write_addr(write_addr),
    .write_dq(write_dq), .write_dq_oe(write_dq_oe),
    .read_req(read_req), .read_ack(read_ack), .read_end(read_end),
    .read_cmd(read_cmd), .read_ba(read_ba), .read_addr(read_addr),
    .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sysclk_100M = ~sysclk_100M;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // reference model: who owns the bus, who got a grant this cycle, RR history
  int m_owner;
  bit m_wr_was_last;
  bit m_gnt_ref, m_gnt_wr, m_gnt_rd;

  // requester behaviour
  bit rq_en;
  int ref_busy, wr_busy, rd_busy;
  int n_gnt_ref, n_gnt_wr, n_gnt_rd;

  function automatic int pick_winner(bit rf, bit wr, bit rd, bit wr_last);
    if (rf)            return O_REF;
    if (wr && rd)      return wr_last ? O_RD : O_WR;
    if (wr)            return O_WR;
    if (rd)            return O_RD;
    return O_IDLE;
  endfunction

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_edge();
    int nxt;
    m_gnt_ref = 0; m_gnt_wr = 0; m_gnt_rd = 0;
    if (!rst_n) begin
      m_owner = O_INIT; m_wr_was_last = 0;
      return;
    end
    nxt = m_owner;
    if (m_owner == O_INIT && init_end) nxt = O_IDLE;
    else if (m_owner == O_IDLE) begin
      nxt = pick_winner(refresh_req, write_req, read_req, m_wr_was_last);
      m_gnt_ref = (nxt == O_REF);
      m_gnt_wr  = (nxt == O_WR);
      m_gnt_rd  = (nxt == O_RD);
    end
    else if (m_owner == O_REF && refresh_end) nxt = O_IDLE;
    else if (m_owner == O_WR && write_end) begin nxt = O_IDLE; m_wr_was_last = 1; end
    else if (m_owner == O_RD && read_end)  begin nxt = O_IDLE; m_wr_was_last = 0; end
    m_owner = nxt;
  endtask

  task automatic check_outputs();
    logic [3:0]    e_cmd;
    logic [BW-1:0] e_ba;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dq;
    logic          e_oe;
    e_cmd = 4'b0111; e_ba = '0; e_addr = '0; e_dq = '0; e_oe = 1'b0;
    case (m_owner)
      O_INIT: begin e_cmd = init_cmd; e_ba = init_ba; e_addr = init_addr; end
      O_REF:  e_cmd = refresh_cmd;
      O_WR:   begin e_cmd = write_cmd; e_ba = write_ba; e_addr = write_addr;
                    e_dq = write_dq; e_oe = write_dq_oe; end
      O_RD:   begin e_cmd = read_cmd; e_ba = read_ba; e_addr = read_addr; end
      default: ;
    endcase
    chk("refresh_ack", 32'(refresh_ack), 32'(m_gnt_ref));
    chk("write_ack",   32'(write_ack),   32'(m_gnt_wr));
    chk("read_ack",    32'(read_ack),    32'(m_gnt_rd));
    chk("sdram_cmd",   32'(sdram_cmd),   32'(e_cmd));
    chk("sdram_ba",    32'(sdram_ba),    32'(e_ba));
    chk("sdram_addr",  32'(sdram_addr),  32'(e_addr));
    chk("sdram_dq",    32'(sdram_dq_out), 32'(e_dq));
    chk("sdram_dq_oe", 32'(sdram_dq_oe), 32'(e_oe));
  endtask

  task automatic randomize_buses();
    init_cmd    = 4'($urandom);  init_ba  = BW'($urandom); init_addr = AW'($urandom);
    refresh_cmd = 4'($urandom_range(0, 1) ? 1 : $urandom);
    write_cmd   = 4'($urandom);  write_ba = BW'($urandom); write_addr = AW'($urandom);
    write_dq    = DW'($urandom); write_dq_oe = 1'($urandom);
    read_cmd    = 4'($urandom);  read_ba  = BW'($urandom); read_addr = AW'($urandom);
  endtask

  task automatic reset_requesters();
    refresh_req = 0; refresh_end = 0; write_req = 0; write_end = 0;
    read_req = 0; read_end = 0; ref_busy = 0; wr_busy = 0; rd_busy = 0;
  endtask

  // Requesters hold req until ack, then work for a random time and pulse end.
  // Occasional stray end pulses come from requesters that do not own the bus.
  task automatic drive_requesters();
    refresh_end = 0; write_end = 0; read_end = 0;
    if (refresh_ack) begin refresh_req = 0; ref_busy = $urandom_range(1, 5); n_gnt_ref++; end
    if (write_ack)   begin write_req = 0;   wr_busy  = $urandom_range(1, 6); n_gnt_wr++;  end
    if (read_ack)    begin read_req = 0;    rd_busy  = $urandom_range(1, 6); n_gnt_rd++;  end
    if (ref_busy > 0) begin ref_busy--; if (ref_busy == 0) refresh_end = 1; end
    else if (!refresh_req && $urandom_range(0, 11) == 0) refresh_req = 1;
    else if (m_owner != O_REF && $urandom_range(0, 15) == 0) refresh_end = 1;
    if (wr_busy > 0) begin wr_busy--; if (wr_busy == 0) write_end = 1; end
    else if (!write_req && $urandom_range(0, 2) == 0) write_req = 1;
    else if (m_owner != O_WR && $urandom_range(0, 15) == 0) write_end = 1;
    if (rd_busy > 0) begin rd_busy--; if (rd_busy == 0) read_end = 1; end
    else if (!read_req && $urandom_range(0, 2) == 0) read_req = 1;
    else if (m_owner != O_RD && $urandom_range(0, 15) == 0) read_end = 1;
  endtask

  task automatic step();
    @(posedge sysclk_100M);
    #1;
    model_edge();
    check_outputs();
    randomize_buses();
    if (rq_en) drive_requesters();
  endtask

  initial begin
    int guard;
    rq_en = 0; n_gnt_ref = 0; n_gnt_wr = 0; n_gnt_rd = 0;
    m_owner = O_INIT; m_wr_was_last = 0;
    m_gnt_ref = 0; m_gnt_wr = 0; m_gnt_rd = 0;
    rst_n = 0; init_end = 0;
    reset_requesters();
    randomize_buses();
    repeat (3) step();
    #2 rst_n = 1;

    // init gating: write_req held, bus must follow init_* and no ack may appear
    write_req = 1; read_req = 1; refresh_req = 1;
    repeat (200) step();
    init_end = 1;
    step();
    chk("idle_after_init", 32'(sdram_cmd), 32'h7);
    refresh_req = 0; read_req = 0;
    step();
    chk("first_write_ack", 32'(write_ack), 32'd1);
    rq_en = 1;
    drive_requesters();

    repeat (3000) step();

    // reset while a read burst owns the bus
    guard = 0;
    while (m_owner != O_RD && guard < 500) begin step(); guard++; end
    chk("reached_read", 32'(m_owner), 32'(O_RD));
    #3 rst_n = 0;
    #1;
    m_owner = O_INIT; m_wr_was_last = 0;
    m_gnt_ref = 0; m_gnt_wr = 0; m_gnt_rd = 0;
    check_outputs();
    rq_en = 0;
    reset_requesters();
    repeat (2) step();
    #2 rst_n = 1;
    rq_en = 1;
    repeat (800) step();

    chk("saw_refresh_grants", 32'(n_gnt_ref > 0), 32'd1);
    chk("saw_write_grants",   32'(n_gnt_wr > 0),  32'd1);
    chk("saw_read_grants",    32'(n_gnt_rd > 0),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
